seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider; the inverse operation to the team's combinational shift-add multiplier.
- Takes an unsigned DW-bit dividend and VW-bit divisor and produces a DW-bit quotient and VW-bit remainder.
- Computes one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and is driven through a start/done handshake by the control FSM.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW <= DW).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- A  input  DW  dividend; sampled on the accepted start.
- B  input  VW  divisor; sampled on the accepted start.
- busy  output  1  high from the cycle after start is accepted through the cycle done is high.
- done  output  1  single-cycle pulse; Q, R and dz are valid from this cycle.
- Q  output  DW  quotient.
- R  output  VW  remainder.
- dz  output  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - busy=0, done=0, Q=0, R=0, dz=0; iteration counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches A and B.
  - If B==0: go to DONE with Q = all ones, R = 0, dz=1.
  - Otherwise: clear the partial remainder, load the dividend shift register, set counter=DW-1, dz=0, go to RUN.
- RUN, each cycle one restoring step:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = partial remainder (VW+1 bits) − {0,B}.
  - If trial is non-negative, the partial remainder takes the trial value and the quotient bit is 1; otherwise the partial remainder is kept and the quotient bit is 0.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE:
  - done=1 for exactly one cycle; Q and R are driven from the internal registers.
  - Next state is IDLE.
- Latency:
  - Normal operation: done is high DW+1 cycles after the start-accept edge (9 cycles for defaults).
  - Divide by zero: done is high 1 cycle after the start-accept edge.
- Result holding: Q, R and dz hold their values after done until the next accepted start. On that start Q and R are unchanged until the new DONE.
- start while busy=1 (RUN or DONE) is ignored and not queued.
- A and B may change freely after the accept edge; the latched copies are used.
- Width rules:
  - The partial remainder is VW+1 bits internally so the trial subtraction never overflows.
  - R is its low VW bits.
  - Quotient bits shift into an LSB-first DW-bit register.
- Reset asserted mid-RUN aborts the operation immediately: all outputs return to their reset values and no done is produced.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - A and B are two's complement.
  - At start, take magnitudes; the sign of Q is A[DW-1]^B[VW-1] and the sign of R follows A.
  - Negate the results in DONE; this adds no cycles.
  - Truncation is toward zero.
  - −2^(DW-1) / −1 yields Q = 0x80 (wrap), R = 0.
  - Divide by zero behaves as in unsigned mode.
- Undefined: purely unsigned; no sign logic is synthesised.

Decomposition:
- Package div_pkg holds:
  - Typedef for state enum {IDLE, RUN, DONE}.
  - Localparams for default DW/VW.
  - Counter width $clog2(DW).
  - Constant DZ_QUOT = all ones.
- Sub-module div_step: combinational single restoring step (partial remainder in, divisor, incoming dividend bit → next partial remainder, quotient bit). Instantiated once in the top.
- The FSM, counter and registers stay in seq_divider.

Test Plan:
- A=200, B=7, start pulse → busy for 9 cycles, done on cycle 9; Q=28, R=4, dz=0.
- A=255, B=15 → Q=17, R=0. Then A=5, B=9 → Q=0, R=5. Check that Q holds 17 until the second done.
- A=100, B=0 → done 1 cycle after accept; Q=0xFF, R=0, dz=1. Then a normal divide clears dz.
- start re-pulsed with A=1, B=1 during RUN of A=200, B=7 → ignored; result Q=28, R=4, and exactly one done.
- rst_n low at cycle 4 of a RUN → busy=0, done=0, Q=0, R=0 immediately. A fresh start after reset gives a correct result.
- With DIV_SIGNED_EN:
  - A=0x9C (−100), B=7 → Q=0xF2 (−14), R=0xE (−2).
  - A=0x80, B=0xF → Q=0x80, R=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default sizes for the sequential restoring divider.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;
    localparam int DIV_CW = $clog2(DIV_DW);

    // Quotient reported for a zero divisor.
    localparam logic [DIV_DW-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   rem_i,
    input  logic [VW-1:0] div_i,
    input  logic          bit_i,
    output logic [VW:0]   rem_o,
    output logic          qbit_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;

    // One guard bit above the partial remainder so the borrow is visible as the sign.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {2'b00, div_i};
    assign qbit_o  = ~trial[VW+1];
    assign rem_o   = qbit_o ? trial[VW:0] : shifted[VW:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW:0]   rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] b_q, b_d;
    logic [DW-1:0] q_out_q, q_out_d;
    logic [VW-1:0] r_out_q, r_out_d;
    logic          dz_q, dz_d;

    logic [DW-1:0] a_mag;
    logic [VW-1:0] b_mag;
    logic [VW:0]   rem_nxt;
    logic          qbit;
    logic [DW-1:0] quo_nxt;
    logic [DW-1:0] q_res;
    logic [VW-1:0] r_res;

    div_step #(.VW(VW)) u_step (
        .rem_i  (rem_q),
        .div_i  (b_q),
        .bit_i  (dvd_q[DW-1]),
        .rem_o  (rem_nxt),
        .qbit_o (qbit)
    );

    assign quo_nxt = {quo_q[DW-2:0], qbit};

`ifdef DIV_SIGNED_EN
    logic qneg_q, rneg_q;

    assign a_mag = A[DW-1] ? -A : A;
    assign b_mag = B[VW-1] ? -B : B;
    // Sign fix-up is folded into the final load, so no extra cycle is spent.
    assign q_res = qneg_q ? -quo_nxt : quo_nxt;
    assign r_res = rneg_q ? -(rem_nxt[VW-1:0]) : rem_nxt[VW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            qneg_q <= A[DW-1] ^ B[VW-1];
            rneg_q <= A[DW-1];
        end
    end
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_res = quo_nxt;
    assign r_res = rem_nxt[VW-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        b_d     = b_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d = b_mag;
                    if (B == '0) begin
                        q_out_d = '1;
                        r_out_d = '0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = a_mag;
                        quo_d   = '0;
                        cnt_d   = CW'(DW - 1);
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nxt;
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                quo_d = quo_nxt;
                if (cnt_q == '0) begin
                    q_out_d = q_res;
                    r_out_d = r_res;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Q    = q_out_q;
    assign R    = r_out_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vectors, expected {dz,Q,R} queued at issue and checked on done.
module tb_seq_divider;
    import div_pkg::*;

    localparam int DW = 8;
    localparam int VW = 4;
    localparam int W  = 1 + DW + VW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] A;
    logic [VW-1:0] B;
    logic          busy;
    logic          done;
    logic [DW-1:0] Q;
    logic [VW-1:0] R;
    logic          dz;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           checks;
    int           errors;
    int           cyc;
    int           busy_cnt;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [W-1:0] e;
                    int           l;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("result_dz_q_r", int'({dz, Q, R}), int'(e));
                    check("done_latency", cyc, l);
                end
            end
        end
    end

    // drivers
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        busy_cnt = 0;
        exp_q.push_back({edz, eq, er});
        lat_q.push_back(cyc + (edz ? 1 : DW + 1));
        @(negedge clk);
        start = 1'b0;
        A     = DW'($urandom_range(0, 255));
        B     = VW'($urandom_range(0, 15));
    endtask

    task automatic pulse_start(input logic [DW-1:0] a, input logic [VW-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        busy_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_q", int'(Q), 0);
        check("reset_r", int'(R), 0);
        check("reset_dz", int'(dz), 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DIV_SIGNED_EN
        issue(8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0);
        wait_drain(40);
        issue(8'h80, 4'hF, 8'h80, 4'h0, 1'b0);
        wait_drain(40);
        issue(8'h64, 4'h9, 8'hF2, 4'h2, 1'b0);
        wait_drain(40);
        issue(8'h64, 4'h0, DZ_QUOT, 4'h0, 1'b1);
        wait_drain(40);
`else
        // basic divide plus busy width
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        wait_drain(40);
        check("busy_cycles", busy_cnt, DW + 1);

        // result holds through the next operation
        issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
        wait_drain(40);
        issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
        check("hold_q_early", int'(Q), 17);
        repeat (4) @(negedge clk);
        check("hold_q_mid", int'(Q), 17);
        check("hold_r_mid", int'(R), 0);
        wait_drain(40);

        // divide by zero, then a normal divide clears dz
        issue(8'd100, 4'd0, DZ_QUOT, 4'd0, 1'b1);
        wait_drain(40);
        check("dz_hold", int'(dz), 1);
        issue(8'd50, 4'd7, 8'd7, 4'd1, 1'b0);
        wait_drain(40);

        // start while busy is ignored; one done only
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (2) @(negedge clk);
        pulse_start(8'd1, 4'd1);
        wait_drain(40);
        repeat (12) @(negedge clk);

        // reset mid-run aborts
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        lat_q.delete();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(Q), 0);
        check("abort_r", int'(R), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0);
        wait_drain(40);

        // boundaries
        issue(8'd0, 4'd3, 8'd0, 4'd0, 1'b0);
        wait_drain(40);
        issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        wait_drain(40);
        issue(8'd9, 4'd9, 8'd1, 4'd0, 1'b0);
        wait_drain(40);
        issue(8'd14, 4'd15, 8'd0, 4'd14, 1'b0);
        wait_drain(40);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
